// File: rtl/memory_port_arbiter.sv
// Shares one single-ported synchronous memory between an instruction-fetch and a
// data-access requester; data wins conflicts, and each side is blocked in its own ready cycle.
module memory_port_arbiter #(
    parameter int BIT_COUNT     = 32,
    parameter int BYTE_EN_WIDTH = BIT_COUNT / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     IReq,
    input  logic [BIT_COUNT-1:0]     IAdr,
    output logic                     IReady,
    output logic [BIT_COUNT-1:0]     IData,
    input  logic                     DReq,
    input  logic                     DWrite,
    input  logic [BYTE_EN_WIDTH-1:0] DByteEn,
    input  logic [BIT_COUNT-1:0]     DAdr,
    input  logic [BIT_COUNT-1:0]     DWriteData,
    output logic                     DReady,
    output logic [BIT_COUNT-1:0]     DReadData,
    output logic                     MemEn,
    output logic                     MemWrite,
    output logic [BYTE_EN_WIDTH-1:0] MemByteEn,
    output logic [BIT_COUNT-1:0]     MemAdr,
    output logic [BIT_COUNT-1:0]     MemWriteData,
    input  logic [BIT_COUNT-1:0]     MemReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_COUNT-1:0] i_hold_q, i_hold_d;
    logic [BIT_COUNT-1:0] d_hold_q, d_hold_d;
    logic                 i_cand, d_cand;

    always_comb begin
        state_d      = IDLE;
        MemEn        = 1'b0;
        MemWrite     = 1'b0;
        MemByteEn    = '0;
        MemAdr       = '0;
        MemWriteData = '0;
        i_hold_d     = i_hold_q;
        d_hold_d     = d_hold_q;

        // A side whose ready pulse is in this cycle still has Req high from the
        // finished access, so it must sit out one cycle; this also forces alternation.
        i_cand = !reset && IReq && (state_q != WAIT_I);
        d_cand = !reset && DReq && (state_q != WAIT_D);

        if (d_cand) begin
            state_d      = WAIT_D;
            MemEn        = 1'b1;
            MemWrite     = DWrite;
            MemByteEn    = DByteEn;
            MemAdr       = DAdr;
            MemWriteData = DWriteData;
        end else if (i_cand) begin
            state_d = WAIT_I;
            MemEn   = 1'b1;
            MemAdr  = IAdr;
        end

        IReady = !reset && (state_q == WAIT_I);
        DReady = !reset && (state_q == WAIT_D);

        if (IReady) begin
            i_hold_d = MemReadData;
        end
        if (DReady) begin
            d_hold_d = MemReadData;
        end

        // Reset also hides the held values so an abandoned access never leaks out.
        IData     = IReady ? MemReadData : (reset ? '0 : i_hold_q);
        DReadData = DReady ? MemReadData : (reset ? '0 : d_hold_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            i_hold_q <= i_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a read-first synchronous byte-writable memory model.
module tb_memory_port_arbiter;

    logic        clk;
    logic        reset;
    logic        IReq;
    logic [31:0] IAdr;
    logic        IReady;
    logic [31:0] IData;
    logic        DReq;
    logic        DWrite;
    logic [3:0]  DByteEn;
    logic [31:0] DAdr;
    logic [31:0] DWriteData;
    logic        DReady;
    logic [31:0] DReadData;
    logic        MemEn;
    logic        MemWrite;
    logic [3:0]  MemByteEn;
    logic [31:0] MemAdr;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;

    int tests;
    int fails;

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [31:0] poke_adr;
    logic [31:0] poke_data;

    memory_port_arbiter #(.BIT_COUNT(32), .BYTE_EN_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .IReq         (IReq),
        .IAdr         (IAdr),
        .IReady       (IReady),
        .IData        (IData),
        .DReq         (DReq),
        .DWrite       (DWrite),
        .DByteEn      (DByteEn),
        .DAdr         (DAdr),
        .DWriteData   (DWriteData),
        .DReady       (DReady),
        .DReadData    (DReadData),
        .MemEn        (MemEn),
        .MemWrite     (MemWrite),
        .MemByteEn    (MemByteEn),
        .MemAdr       (MemAdr),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read returns the pre-write contents one cycle after issue.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_adr[7:2]] <= poke_data;
        end else if (MemEn) begin
            MemReadData <= mem[MemAdr[7:2]];
            if (MemWrite) begin
                for (int b = 0; b < 4; b++) begin
                    if (MemByteEn[b]) mem[MemAdr[7:2]][8*b +: 8] <= MemWriteData[8*b +: 8];
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] adr, input logic [31:0] data);
        poke_en   = 1'b1;
        poke_adr  = adr;
        poke_data = data;
        next_cycle();
        poke_en   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; IReq = 1'b1; IAdr = 32'h4; DReq = 1'b1; DWrite = 1'b1;
        DByteEn = 4'hF; DAdr = 32'h14; DWriteData = 32'hFFFF_FFFF;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b0 || MemWrite !== 1'b0 || MemByteEn !== 4'h0 || MemAdr !== 32'h0) begin
            fails++;
            $display("FAIL reset_mem: MemEn=%b MemWrite=%b MemByteEn=%h MemAdr=%h, required all zero", MemEn, MemWrite, MemByteEn, MemAdr);
        end
        tests++;
        if (IReady !== 1'b0 || DReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: IReady=%b DReady=%b, required 0 0", IReady, DReady);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (IData !== 32'h0 || DReadData !== 32'h0) begin
            fails++;
            $display("FAIL reset_hold: IData=%h DReadData=%h, required 0 0", IData, DReadData);
        end
        next_cycle();
        reset = 1'b0; IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0; DByteEn = 4'h0;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b0 || IReady !== 1'b0 || DReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: MemEn=%b IReady=%b DReady=%b, required 0 0 0", MemEn, IReady, DReady);
        end
        $display("[TB] reset checked");
        next_cycle();
    endtask

    task automatic test_single_fetch;
        poke(32'h8, 32'h0050_0093);
        IReq = 1'b1; IAdr = 32'h8;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemWrite !== 1'b0 || MemAdr !== 32'h8 || MemByteEn !== 4'h0) begin
            fails++;
            $display("FAIL fetch_issue: MemEn=%b MemWrite=%b MemAdr=%h MemByteEn=%h, required 1 0 00000008 0", MemEn, MemWrite, MemAdr, MemByteEn);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (IReady !== 1'b1 || IData !== 32'h0050_0093) begin
            fails++;
            $display("FAIL fetch_ready: IReady=%b IData=%h, required 1 00500093", IReady, IData);
        end
        tests++;
        if (MemEn !== 1'b0) begin
            fails++;
            $display("FAIL fetch_blocked: MemEn=%b in ready cycle, required 0", MemEn);
        end
        next_cycle();
        IReq = 1'b0;
        @(negedge clk);
        tests++;
        if (IReady !== 1'b0 || IData !== 32'h0050_0093) begin
            fails++;
            $display("FAIL fetch_hold: IReady=%b IData=%h, required 0 00500093", IReady, IData);
        end
        $display("[TB] fetch 0x8 -> %h", IData);
        next_cycle();
    endtask

    task automatic test_conflict;
        poke(32'h20, 32'hCAFE_F00D);
        poke(32'h0, 32'h1234_5678);
        IReq = 1'b1; IAdr = 32'h0; DReq = 1'b1; DWrite = 1'b0; DAdr = 32'h20; DByteEn = 4'h0;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemAdr !== 32'h20 || MemWrite !== 1'b0) begin
            fails++;
            $display("FAIL conflict_d_first: MemEn=%b MemAdr=%h MemWrite=%b, required 1 00000020 0", MemEn, MemAdr, MemWrite);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (DReady !== 1'b1 || DReadData !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL conflict_d_ready: DReady=%b DReadData=%h, required 1 cafef00d", DReady, DReadData);
        end
        tests++;
        if (MemEn !== 1'b1 || MemAdr !== 32'h0 || IReady !== 1'b0) begin
            fails++;
            $display("FAIL conflict_i_issue: MemEn=%b MemAdr=%h IReady=%b, required 1 00000000 0", MemEn, MemAdr, IReady);
        end
        next_cycle();
        DReq = 1'b0;
        @(negedge clk);
        tests++;
        if (IReady !== 1'b1 || IData !== 32'h1234_5678 || DReady !== 1'b0 || MemEn !== 1'b0) begin
            fails++;
            $display("FAIL conflict_i_ready: IReady=%b IData=%h DReady=%b MemEn=%b, required 1 12345678 0 0", IReady, IData, DReady, MemEn);
        end
        $display("[TB] conflict D 0x20 -> %h, I 0x0 -> %h", DReadData, IData);
        next_cycle();
        IReq = 1'b0;
        next_cycle();
    endtask

    task automatic store_then_load(input logic [31:0] adr, input logic [3:0] be,
                                   input logic [31:0] wdata, input logic [31:0] expect_rd,
                                   input string name);
        DReq = 1'b1; DWrite = 1'b1; DAdr = adr; DByteEn = be; DWriteData = wdata;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemWrite !== 1'b1 || MemAdr !== adr || MemByteEn !== be || MemWriteData !== wdata) begin
            fails++;
            $display("FAIL %s_store_issue: MemEn=%b MemWrite=%b MemAdr=%h MemByteEn=%h MemWriteData=%h, required 1 1 %h %h %h",
                     name, MemEn, MemWrite, MemAdr, MemByteEn, MemWriteData, adr, be, wdata);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (DReady !== 1'b1 || MemEn !== 1'b0) begin
            fails++;
            $display("FAIL %s_store_ready: DReady=%b MemEn=%b, required 1 0", name, DReady, MemEn);
        end
        next_cycle();
        DWrite = 1'b0; DByteEn = 4'h0; DWriteData = 32'h0;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemWrite !== 1'b0 || MemAdr !== adr || DReady !== 1'b0) begin
            fails++;
            $display("FAIL %s_load_issue: MemEn=%b MemWrite=%b MemAdr=%h DReady=%b, required 1 0 %h 0", name, MemEn, MemWrite, MemAdr, DReady, adr);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (DReady !== 1'b1 || DReadData !== expect_rd) begin
            fails++;
            $display("FAIL %s_load_data: DReady=%b DReadData=%h, required 1 %h", name, DReady, DReadData, expect_rd);
        end
        $display("[TB] %s store %h be=%h @%h, reload -> %h", name, wdata, be, adr, DReadData);
        next_cycle();
        DReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_store_load;
        store_then_load(32'h10, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "full");
    endtask

    task automatic test_partial_store;
        poke(32'h30, 32'h1111_1111);
        store_then_load(32'h30, 4'b0011, 32'h0000_ABCD, 32'h1111_ABCD, "partial");
    endtask

    task automatic test_back_to_back;
        int d_ready_cnt;
        int i_ready_cnt;
        d_ready_cnt = 0;
        i_ready_cnt = 0;
        IReq = 1'b1; IAdr = 32'h8; DReq = 1'b1; DWrite = 1'b0; DAdr = 32'h10; DByteEn = 4'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tests++;
            if (MemEn !== 1'b1) begin
                fails++;
                $display("FAIL contention_busy: cycle %0d MemEn=%b, required 1", c, MemEn);
            end
            tests++;
            if (MemAdr !== ((c % 2 == 1) ? 32'h10 : 32'h8)) begin
                fails++;
                $display("FAIL contention_grant: cycle %0d MemAdr=%h, required %h", c, MemAdr, (c % 2 == 1) ? 32'h10 : 32'h8);
            end
            if (DReady === 1'b1) begin
                d_ready_cnt++;
                tests++;
                if (DReadData !== 32'hDEAD_BEEF) begin
                    fails++;
                    $display("FAIL contention_ddata: cycle %0d DReadData=%h, required deadbeef", c, DReadData);
                end
            end
            if (IReady === 1'b1) begin
                i_ready_cnt++;
                tests++;
                if (IData !== 32'h0050_0093) begin
                    fails++;
                    $display("FAIL contention_idata: cycle %0d IData=%h, required 00500093", c, IData);
                end
            end
            next_cycle();
        end
        tests++;
        if (d_ready_cnt != 5 || i_ready_cnt != 4) begin
            fails++;
            $display("FAIL contention_counts: DReady=%0d IReady=%0d pulses, required 5 4", d_ready_cnt, i_ready_cnt);
        end
        DReq = 1'b0;
        @(negedge clk);
        tests++;
        if (IReady !== 1'b1 || MemEn !== 1'b0) begin
            fails++;
            $display("FAIL contention_tail: IReady=%b MemEn=%b, required 1 0", IReady, MemEn);
        end
        $display("[TB] contention: %0d D and %0d I completions in 10 cycles", d_ready_cnt, i_ready_cnt);
        next_cycle();
        IReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid;
        IReq = 1'b1; IAdr = 32'h8;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemAdr !== 32'h8) begin
            fails++;
            $display("FAIL midreset_issue: MemEn=%b MemAdr=%h, required 1 00000008", MemEn, MemAdr);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (IReady !== 1'b0 || IData !== 32'h0 || MemEn !== 1'b0) begin
            fails++;
            $display("FAIL midreset_gate: IReady=%b IData=%h MemEn=%b, required 0 00000000 0", IReady, IData, MemEn);
        end
        next_cycle();
        reset = 1'b0; IReq = 1'b0;
        @(negedge clk);
        tests++;
        if (IReady !== 1'b0 || IData !== 32'h0 || MemEn !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: IReady=%b IData=%h MemEn=%b, required 0 00000000 0", IReady, IData, MemEn);
        end
        next_cycle();
        IReq = 1'b1;
        @(negedge clk);
        tests++;
        if (MemEn !== 1'b1 || MemAdr !== 32'h8) begin
            fails++;
            $display("FAIL midreset_reissue: MemEn=%b MemAdr=%h, required 1 00000008", MemEn, MemAdr);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (IReady !== 1'b1 || IData !== 32'h0050_0093) begin
            fails++;
            $display("FAIL midreset_ready: IReady=%b IData=%h, required 1 00500093", IReady, IData);
        end
        $display("[TB] fetch after mid-reset -> %h", IData);
        next_cycle();
        IReq = 1'b0;
        next_cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        poke_en = 1'b0; poke_adr = 32'h0; poke_data = 32'h0;
        reset = 1'b1; IReq = 1'b0; IAdr = 32'h0; DReq = 1'b0; DWrite = 1'b0;
        DByteEn = 4'h0; DAdr = 32'h0; DWriteData = 32'h0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store_load();
        test_partial_store();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
